// File: rtl/led_count_game.sv
// led_count_game: bouncing LED fill-bar guessing game with limited tries and hints.
// The bar grows/shrinks once per tick; GO/STOP freezes it and compares k to a random target.
// Optional feature macro: LED_COUNT_SPEEDUP_EN (each miss halves the tick period, floor 2).
module led_count_game #(
    parameter int unsigned N_LEDS      = 16,
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned MAX_TRIES   = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int unsigned CW         = $clog2(N_LEDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              btn_go_stop,
    output logic [N_LEDS-1:0] led,
    output logic [19:0]       seg_data,
    output logic [CW-1:0]     target,
    output logic              game_over,
    output logic              won
);

    localparam int unsigned TW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
    localparam int unsigned PW = $clog2(TICK_CYCLES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_HINT  = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd5;

    localparam logic [4:0] C_N     = 5'h0A;
    localparam logic [4:0] C_L     = 5'h0B;
    localparam logic [4:0] C_D     = 5'h0C;
    localparam logic [4:0] C_U     = 5'h0D;
    localparam logic [4:0] C_P     = 5'h0E;
    localparam logic [4:0] C_BLANK = 5'h0F;

    logic [2:0]        state;
    logic [CW-1:0]     k;
    logic              dir_up;
    logic [TW-1:0]     tries;
    logic [PW-1:0]     tick_cnt;
    logic [PW-1:0]     period;
    logic              btn_prev;
    logic [15:0]       lfsr;

    logic              press;
    logic              tick;
    logic              hit;
    logic [CW-1:0]     k_step;
    logic              dir_step;
    logic [TW-1:0]     tries_miss;
    logic [CW-1:0]     target_new;
    logic [N_LEDS-1:0] bar;
    logic [N_LEDS-1:0] led_n;
    logic [19:0]       seg_n;
    logic              game_over_n;
    logic              won_n;

    // Two display codes: tens then units (values never exceed 99).
    function automatic logic [9:0] dec2(input logic [CW-1:0] v);
        int unsigned val;
        val = 32'(v);
        return {5'(val / 32'd10), 5'(val % 32'd10)};
    endfunction

    // Edge detect, tick compare, bounce step and miss bookkeeping.
    always_comb begin
        press    = btn_go_stop & ~btn_prev;
        tick     = (tick_cnt == period - PW'(1));
        hit      = (k == target);
        k_step   = k;
        dir_step = dir_up;
        if (dir_up) begin
            if (k == CW'(N_LEDS)) begin
                dir_step = 1'b0;
                k_step   = k - CW'(1);
            end else begin
                k_step = k + CW'(1);
            end
        end else begin
            if (k == CW'(1)) begin
                dir_step = 1'b1;
                k_step   = k + CW'(1);
            end else begin
                k_step = k - CW'(1);
            end
        end
        // Unlimited tries when MAX_TRIES is zero: the counter never moves.
        tries_miss = (MAX_TRIES == 0) ? tries : tries - TW'(1);
        target_new = CW'(32'(lfsr) % N_LEDS + 32'd1);
    end

    // Game state machine; a press in RUN takes priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            state    <= ST_IDLE;
            k        <= '0;
            dir_up   <= 1'b1;
            tries    <= TW'(MAX_TRIES);
            tick_cnt <= '0;
            target   <= CW'(1);
        end else begin
            case (state)
                ST_IDLE: begin
                    target   <= target_new;
                    k        <= CW'(1);
                    dir_up   <= 1'b1;
                    tries    <= TW'(MAX_TRIES);
                    tick_cnt <= '0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (press) begin
                        state <= ST_CHECK;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        k        <= k_step;
                        dir_up   <= dir_step;
                    end else begin
                        tick_cnt <= tick_cnt + PW'(1);
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        state <= ST_WIN;
                    end else begin
                        tries <= tries_miss;
                        state <= (MAX_TRIES != 0 && tries_miss == '0) ? ST_LOSE : ST_HINT;
                    end
                end
                ST_HINT: begin
                    if (press) begin
                        tick_cnt <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (press) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LED_COUNT_SPEEDUP_EN
    logic [PW-1:0] period_half;
    assign period_half = ((period >> 1) < PW'(2)) ? PW'(2) : (period >> 1);

    // Tick period: halves on every miss, restored whenever a round restarts.
    always_ff @(posedge clk) begin
        if (reset || !active || state == ST_IDLE) begin
            period <= PW'(TICK_CYCLES);
        end else if (state == ST_CHECK && !hit) begin
            period <= period_half;
        end
    end
`else
    assign period = PW'(TICK_CYCLES);
`endif

    // Free-running LFSR (x^16+x^15+x^13+x^4+1); keeps running while the mode is inactive.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
    end

    // Button history tracks the raw level every cycle, even while inactive.
    always_ff @(posedge clk) begin
        if (reset) btn_prev <= 1'b0;
        else       btn_prev <= btn_go_stop;
    end

    // Next output values decoded from the current state.
    always_comb begin
        for (int i = 0; i < int'(N_LEDS); i++) begin
            bar[i] = (i + int'(k)) >= int'(N_LEDS);
        end
        led_n       = bar;
        seg_n       = {C_BLANK, C_BLANK, dec2(target)};
        game_over_n = (state == ST_WIN) || (state == ST_LOSE);
        won_n       = (state == ST_WIN);
        case (state)
            ST_IDLE: begin
                led_n = '0;
                seg_n = {4{C_BLANK}};
            end
            ST_HINT: seg_n = {dec2(k), (k < target) ? {C_U, C_P} : {C_D, C_N}};
            ST_WIN:  seg_n = {5'h09, 5'h00, 5'h00, C_D};
            ST_LOSE: begin
                led_n = '1;
                seg_n = {C_L, C_BLANK, dec2(target)};
            end
            default: ;
        endcase
    end

    // Registered outputs, one cycle behind the state they describe.
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            led       <= '0;
            seg_data  <= {4{C_BLANK}};
            game_over <= 1'b0;
            won       <= 1'b0;
        end else begin
            led       <= led_n;
            seg_data  <= seg_n;
            game_over <= game_over_n;
            won       <= won_n;
        end
    end

endmodule

// File: tb/tb_led_count_game.sv
// tb_led_count_game: directed bench for led_count_game.
// Instance a: 8 LEDs, tick 4, 3 tries, target 5.  Instance b: 2 tries, target 2.
// Instance c: tick 8, unlimited tries, target 5; measures the tick period after misses.
module tb_led_count_game;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  act;
    logic [2:0]  btn;
    logic [7:0]  led_a, led_b, led_c;
    logic [19:0] seg_a, seg_b, seg_c;
    logic [3:0]  tgt_a, tgt_b, tgt_c;
    logic        go_a, go_b, go_c;
    logic        won_a, won_b, won_c;
    logic [15:0] m_lfsr;
    logic [3:0]  exp_t;
    int          checks;
    int          errors;
    int          m;

    typedef struct {
        logic       btn;
        logic [7:0] led;
    } vec_t;

    vec_t       path_tab[16];
    int         per_exp[5];
    logic [7:0] per_want[4];

    localparam logic [19:0] BLANK4 = 20'h7BDEF;

    led_count_game #(.N_LEDS(8), .TICK_CYCLES(4), .MAX_TRIES(3), .LFSR_SEED(16'hACE4)) u_a (
        .clk(clk), .reset(rst[0]), .active(act[0]), .btn_go_stop(btn[0]),
        .led(led_a), .seg_data(seg_a), .target(tgt_a), .game_over(go_a), .won(won_a)
    );

    led_count_game #(.N_LEDS(8), .TICK_CYCLES(4), .MAX_TRIES(2), .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .reset(rst[1]), .active(act[1]), .btn_go_stop(btn[1]),
        .led(led_b), .seg_data(seg_b), .target(tgt_b), .game_over(go_b), .won(won_b)
    );

    led_count_game #(.N_LEDS(8), .TICK_CYCLES(8), .MAX_TRIES(0), .LFSR_SEED(16'hACE4)) u_c (
        .clk(clk), .reset(rst[2]), .active(act[2]), .btn_go_stop(btn[2]),
        .led(led_c), .seg_data(seg_c), .target(tgt_c), .game_over(go_c), .won(won_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for instance a: x^16+x^15+x^13+x^4+1, shift left, runs unless reset.
    always @(posedge clk) begin
        if (rst[0]) m_lfsr <= 16'hACE4;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end

    function automatic logic [19:0] seg4(input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] c, input logic [4:0] d);
        return {a, b, c, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic press(input int u);
        btn[u] = 1'b1;
        step();
        btn[u] = 1'b0;
    endtask

    // Cycles until instance c's bar shows the wanted pattern; 0 if it never does.
    task automatic measure(input logic [7:0] want, output int cyc);
        cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (led_c == want) begin
                cyc = n;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        path_tab[0]  = '{1'b0, 8'h80};
        path_tab[1]  = '{1'b0, 8'hC0};
        path_tab[2]  = '{1'b0, 8'hE0};
        path_tab[3]  = '{1'b0, 8'hF0};
        path_tab[4]  = '{1'b0, 8'hF8};
        path_tab[5]  = '{1'b0, 8'hFC};
        path_tab[6]  = '{1'b0, 8'hFE};
        path_tab[7]  = '{1'b0, 8'hFF};
        path_tab[8]  = '{1'b0, 8'hFE};
        path_tab[9]  = '{1'b0, 8'hFC};
        path_tab[10] = '{1'b0, 8'hF8};
        path_tab[11] = '{1'b0, 8'hF0};
        path_tab[12] = '{1'b0, 8'hE0};
        path_tab[13] = '{1'b0, 8'hC0};
        path_tab[14] = '{1'b0, 8'h80};
        path_tab[15] = '{1'b0, 8'hC0};
        per_want[0] = 8'hC0;
        per_want[1] = 8'hE0;
        per_want[2] = 8'hF0;
        per_want[3] = 8'hF8;
`ifdef LED_COUNT_SPEEDUP_EN
        per_exp[0] = 8; per_exp[1] = 4; per_exp[2] = 2; per_exp[3] = 2; per_exp[4] = 8;
`else
        per_exp[0] = 8; per_exp[1] = 8; per_exp[2] = 8; per_exp[3] = 8; per_exp[4] = 8;
`endif

        rst = 3'b111;
        act = 3'b111;
        btn = 3'b000;
        step();
        step();
        chk("reset_led", led_a, 8'h00);
        chk("reset_seg", seg_a, BLANK4);
        chk("reset_target", tgt_a, 4'd1);
        chk("reset_game_over", go_a, 1'b0);
        chk("reset_won", won_a, 1'b0);

        // IDLE -> RUN loads target 5 from the seed; outputs still show IDLE.
        rst = 3'b000;
        step();
        chk("idle_target", tgt_a, 4'd5);
        chk("idle_led", led_a, 8'h00);

        // Bar path 1..8..1..2, four cycles per step.
        for (int j = 0; j < 16; j++) begin
            btn[0] = path_tab[j].btn;
            for (int c = 0; c < 4; c++) begin
                step();
                chk("bar_led", led_a, path_tab[j].led);
                if (c == 0) chk("run_seg", seg_a, seg4(5'h0F, 5'h0F, 5'h00, 5'h05));
            end
        end

        // Miss at k=3 (target 5): display reads 0, 3, U, P.
        press(0);
        step();
        step();
        chk("hint_seg", seg_a, seg4(5'h00, 5'h03, 5'h0D, 5'h0E));
        chk("hint_led", led_a, 8'hE0);
        chk("hint_game_over", go_a, 1'b0);

        // Resume from k=3, still climbing, with a fresh tick count.
        press(0);
        step();
        chk("resume_led0", led_a, 8'hE0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("resume_led", led_a, 8'hE0);
        end
        step();
        chk("resume_next", led_a, 8'hF0);

        // Win at k=5.
        repeat (3) step();
        press(0);
        step();
        step();
        chk("win_seg", seg_a, seg4(5'h09, 5'h00, 5'h00, 5'h0C));
        chk("win_won", won_a, 1'b1);
        chk("win_game_over", go_a, 1'b1);
        chk("win_led", led_a, 8'hF8);

        // New round: target from the running LFSR.
        press(0);
        exp_t = {1'b0, m_lfsr[2:0]} + 4'd1;
        step();
        chk("new_target", tgt_a, exp_t);
        chk("new_won", won_a, 1'b0);
        chk("new_game_over", go_a, 1'b0);

        // Drop active mid-RUN.
        step();
        chk("pre_abort_led", led_a, 8'h80);
        act[0] = 1'b0;
        step();
        chk("abort_led", led_a, 8'h00);
        chk("abort_seg", seg_a, BLANK4);
        chk("abort_target", tgt_a, 4'd1);
        chk("abort_game_over", go_a, 1'b0);
        act[0] = 1'b1;
        exp_t = {1'b0, m_lfsr[2:0]} + 4'd1;
        step();
        chk("lfsr_kept_running", tgt_a, exp_t);

        // Lose on instance b: two misses above target 2.
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        step();
        chk("b_target", tgt_b, 4'd2);
        repeat (8) step();
        press(1);
        step();
        step();
        chk("b_hint_seg", seg_b, seg4(5'h00, 5'h03, 5'h0C, 5'h0A));
        chk("b_hint_game_over", go_b, 1'b0);
        press(1);
        step();
        press(1);
        step();
        step();
        chk("lose_led", led_b, 8'hFF);
        chk("lose_seg_left", {27'd0, seg_b[19:15]}, 32'h0B);
        chk("lose_seg", seg_b, seg4(5'h0B, 5'h0F, 5'h00, 5'h02));
        chk("lose_game_over", go_b, 1'b1);
        chk("lose_won", won_b, 1'b0);

        // Instance c: press on the first tick edge freezes k=1.
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        step();
        repeat (7) step();
        press(2);
        step();
        step();
        chk("simul_seg", seg_c, seg4(5'h00, 5'h01, 5'h0D, 5'h0E));
        chk("simul_led", led_c, 8'h80);

        // Synchronous reset in HINT.
        rst[2] = 1'b1;
        step();
        chk("hint_reset_led", led_c, 8'h00);
        chk("hint_reset_seg", seg_c, BLANK4);
        chk("hint_reset_target", tgt_c, 4'd1);
        chk("hint_reset_game_over", go_c, 1'b0);
        chk("hint_reset_won", won_c, 1'b0);
        rst[2] = 1'b0;
        step();
        chk("c_target", tgt_c, 4'd5);
        step();

        // Tick period after successive misses at k=2,3,4, then win at k=5.
        for (int p = 0; p < 4; p++) begin
            measure(per_want[p], m);
            chk("tick_period", m, per_exp[p]);
            if (p < 3) begin
                press(2);
                step();
                press(2);
                step();
            end
        end
        press(2);
        step();
        step();
        chk("c_won", won_c, 1'b1);
        press(2);
        step();
        step();
        measure(8'hC0, m);
        chk("tick_period_restored", m, per_exp[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
